// File: rtl/snake_pkg.sv
// Shared types and constants for the snake movement controller.
package snake_pkg;

    localparam int GRID_W_DEF = 32;
    localparam int GRID_H_DEF = 24;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, STEP, DEAD} state_t;

    // Opposite directions share bit 1 and differ in bit 0.
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/snake_tick_div.sv
// Move-rate divider: tc pulses on the last of every TICK_DIV enabled cycles.
module snake_tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tc = en && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake head movement controller. Define SNAKE_WRAP_EN to wrap at grid edges
// instead of dying when the head would leave the grid.
module snake_move_ctrl
    import snake_pkg::*;
#(
    parameter int GRID_W   = GRID_W_DEF,
    parameter int GRID_H   = GRID_H_DEF,
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic [1:0] dir_in,
    input  logic       collide,
    output logic [5:0] head_x,
    output logic [5:0] head_y,
    output logic [1:0] cur_dir,
    output logic       step_valid,
    output logic       game_over
);
`ifdef SNAKE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam logic [5:0] X_MAX  = 6'(GRID_W - 1);
    localparam logic [5:0] Y_MAX  = 6'(GRID_H - 1);
    localparam logic [5:0] X_HOME = 6'(GRID_W / 2);
    localparam logic [5:0] Y_HOME = 6'(GRID_H / 2);

    state_t     state, state_nxt;
    logic [1:0] pend_dir;
    logic [5:0] nx, ny;
    logic       at_edge, off_grid;
    logic       tc, tick_en, tick_clr, do_step, restart;

    snake_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .en  (tick_en),
        .tc  (tc)
    );

    // Candidate head position for the pending direction; at_edge flags a move off the grid.
    always_comb begin
        nx      = head_x;
        ny      = head_y;
        at_edge = 1'b0;
        case (pend_dir)
            DIR_UP: begin
                if (head_y == 6'd0) begin at_edge = 1'b1; ny = Y_MAX; end
                else ny = head_y - 6'd1;
            end
            DIR_DOWN: begin
                if (head_y == Y_MAX) begin at_edge = 1'b1; ny = 6'd0; end
                else ny = head_y + 6'd1;
            end
            DIR_RIGHT: begin
                if (head_x == X_MAX) begin at_edge = 1'b1; nx = 6'd0; end
                else nx = head_x + 6'd1;
            end
            default: begin
                if (head_x == 6'd0) begin at_edge = 1'b1; nx = X_MAX; end
                else nx = head_x - 6'd1;
            end
        endcase
    end

    assign off_grid = at_edge && !WRAP;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tick_en   = 1'b0;
        tick_clr  = 1'b0;
        do_step   = 1'b0;
        restart   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin state_nxt = RUN; tick_clr = 1'b1; end
            end
            RUN: begin
                tick_en = !pause;
                if (collide)  state_nxt = DEAD;
                else if (tc)  state_nxt = STEP;
            end
            STEP: begin
                if (collide || off_grid) state_nxt = DEAD;
                else begin state_nxt = RUN; do_step = 1'b1; end
            end
            default: begin
                if (start) begin state_nxt = RUN; tick_clr = 1'b1; restart = 1'b1; end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_x     <= X_HOME;
            head_y     <= Y_HOME;
            cur_dir    <= DIR_UP;
            pend_dir   <= DIR_UP;
            step_valid <= 1'b0;
        end else begin
            step_valid <= do_step;
            if (restart) begin
                head_x   <= X_HOME;
                head_y   <= Y_HOME;
                cur_dir  <= DIR_UP;
                pend_dir <= DIR_UP;
            end else begin
                if (do_step) begin
                    head_x  <= nx;
                    head_y  <= ny;
                    cur_dir <= pend_dir;
                end
                if (!is_reverse(dir_in, cur_dir))
                    pend_dir <= dir_in;
            end
        end
    end

    assign game_over = (state == DEAD);

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Randomised scoreboard bench for snake_move_ctrl against a game-rule model.
module tb_snake_move_ctrl;
    localparam int W  = 32;
    localparam int H  = 24;
    localparam int TD = 4;
`ifdef SNAKE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, pause, collide;
    logic [1:0] dir_in;
    logic [5:0] head_x, head_y;
    logic [1:0] cur_dir;
    logic       step_valid, game_over;

    int errors = 0;
    int checks = 0;

    typedef struct {int x; int y; int d;} step_t;
    step_t exp_q[$];

    // Game model: mode 0 = waiting, 1 = playing, 2 = dead.
    int m_mode = 0, m_x = W/2, m_y = H/2, m_dir = 0, m_pend = 0, m_cnt = 0;
    bit m_stepping = 1'b0;

    snake_move_ctrl #(.GRID_W(W), .GRID_H(H), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .dir_in(dir_in),
        .collide(collide), .head_x(head_x), .head_y(head_y), .cur_dir(cur_dir),
        .step_valid(step_valid), .game_over(game_over)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin : model
        int nx, ny, old_dir;
        bit restart;
        restart = 1'b0;
        old_dir = m_dir;
        if (rst) begin
            m_mode = 0; m_x = W/2; m_y = H/2; m_dir = 0; m_pend = 0;
            m_cnt = 0; m_stepping = 1'b0;
            exp_q.delete();
        end else begin
            if (m_mode == 0) begin
                if (start) begin m_mode = 1; m_cnt = 0; m_stepping = 1'b0; end
            end else if (m_mode == 1) begin
                if (collide) begin
                    m_mode = 2; m_stepping = 1'b0;
                end else if (m_stepping) begin
                    m_stepping = 1'b0;
                    nx = m_x; ny = m_y;
                    case (m_pend)
                        0: ny = ny - 1;
                        1: ny = ny + 1;
                        2: nx = nx + 1;
                        default: nx = nx - 1;
                    endcase
                    if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
                        if (WRAP) begin nx = (nx + W) % W; ny = (ny + H) % H; end
                        else m_mode = 2;
                    end
                    if (m_mode == 1) begin
                        m_x = nx; m_y = ny; m_dir = m_pend;
                        exp_q.push_back('{nx, ny, m_pend});
                    end
                end else if (!pause) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == TD) begin m_cnt = 0; m_stepping = 1'b1; end
                end
            end else if (start) begin
                restart = 1'b1;
                m_x = W/2; m_y = H/2; m_dir = 0; m_pend = 0;
                m_mode = 1; m_cnt = 0; m_stepping = 1'b0;
            end
            // A request for the exact opposite of the current heading is ignored.
            if (!restart && int'(dir_in) != (old_dir ^ 1))
                m_pend = int'(dir_in);
        end
    end

    always @(negedge clk) begin : monitor
        step_t e;
        if (step_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_step: got step to (%0d,%0d) dir %0d, required no step",
                         head_x, head_y, cur_dir);
            end else begin
                e = exp_q.pop_front();
                if (int'(head_x) != e.x || int'(head_y) != e.y || int'(cur_dir) != e.d) begin
                    errors++;
                    $display("FAIL step_value: got (%0d,%0d) dir %0d, required (%0d,%0d) dir %0d",
                             head_x, head_y, cur_dir, e.x, e.y, e.d);
                end
            end
        end else if (exp_q.size() != 0) begin
            checks++;
            errors++;
            e = exp_q.pop_front();
            $display("FAIL missed_step: got step_valid=0, required step to (%0d,%0d) dir %0d",
                     e.x, e.y, e.d);
        end
        checks++;
        if (int'(head_x) != m_x || int'(head_y) != m_y || int'(cur_dir) != m_dir ||
            game_over != (m_mode == 2)) begin
            errors++;
            $display("FAIL state t=%0t: got head=(%0d,%0d) dir=%0d go=%0b, required (%0d,%0d) dir=%0d go=%0b",
                     $time, head_x, head_y, cur_dir, game_over, m_x, m_y, m_dir, m_mode == 2);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bound_fail(input string what);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, required condition within 40 cycles", what);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; collide = 1'b0; dir_in = 2'b00;
        tick(2);
        rst = 1'b0;
        tick(2);

        // Straight up from home: three steps, one every TD+1 cycles.
        start = 1'b1; tick(1); start = 1'b0;
        tick(16);

        // Turn right, then request a reversal (ignored), then turn up.
        dir_in = 2'b10; tick(6);
        dir_in = 2'b11; tick(12);
        dir_in = 2'b00; tick(6);

        // Pause mid-count.
        tick(2);
        pause = 1'b1; tick(10); pause = 1'b0;
        tick(8);

        // Head left until past the x=0 edge.
        dir_in = 2'b11; tick(5 * 22);
        if (m_mode == 2) begin start = 1'b1; tick(1); start = 1'b0; end
        dir_in = 2'b10; tick(3);

        // Collide on the same cycle as the terminal count, then restart.
        for (int i = 0; i < 40 && !(m_mode == 1 && !m_stepping && m_cnt == TD - 1); i++) tick(1);
        if (!(m_mode == 1 && !m_stepping && m_cnt == TD - 1)) bound_fail("wait_terminal");
        collide = 1'b1; tick(1); collide = 1'b0;
        tick(3);
        start = 1'b1; tick(1); start = 1'b0;
        tick(3);

        // Reset while in the step cycle.
        for (int i = 0; i < 40 && !m_stepping; i++) tick(1);
        if (!m_stepping) bound_fail("wait_step");
        rst = 1'b1; tick(1); rst = 1'b0;
        tick(3);

        // Random play.
        start = 1'b1; tick(1); start = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 799) == 0);
            start   = ($urandom_range(0, 19) == 0);
            pause   = ($urandom_range(0, 7) == 0);
            collide = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0) dir_in = 2'($urandom_range(0, 3));
            tick(1);
        end
        rst = 1'b0; start = 1'b0; pause = 1'b0; collide = 1'b0;
        tick(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding steps, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
